sdram_slot_arbiter: RTL and testbench

Two-port arbiter and slot scheduler in front of the Gameboy-style `sdram` controller. The controller runs one access per `sync` slot, which is one `clk8` period, 8 `clk` cycles at 64 MHz; a slot with neither `we` nor `oe` set is used for refresh. This block shares those slots between a high-priority port A (CPU) and a low-priority port B (video/DMA), guarantees periodic refresh slots, prevents starvation of B, and returns read data to the port that issued the read.

---
 rtl/sdram_slot_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: shares the sdram controller's one-access-per-sync slots
// between a high-priority port A and a low-priority port B. It forces a
// refresh slot after REFRESH_EVERY back-to-back accesses, promotes B after
// B_MAX_WAIT slots lost to A, and steers read data back to the issuing port.
module sdram_slot_arbiter #(
  parameter int REFRESH_EVERY = 8,
  parameter int B_MAX_WAIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_ds,
  input  logic [19:0] a_addr,
  input  logic [15:0] a_din,
  output logic        a_ack,
  output logic [15:0] a_dout,
  output logic        a_rvalid,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_ds,
  input  logic [19:0] b_addr,
  input  logic [15:0] b_din,
  output logic        b_ack,
  output logic [15:0] b_dout,
  output logic        b_rvalid,

  output logic        ram_we,
  output logic        ram_oe,
  output logic [1:0]  ram_ds,
  output logic [19:0] ram_addr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout
);

  localparam int ACC_W = (REFRESH_EVERY < 1) ? 1 : $clog2(REFRESH_EVERY + 1);
  localparam int BW_W  = (B_MAX_WAIT < 1) ? 1 : $clog2(B_MAX_WAIT + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(REFRESH_EVERY);
  localparam logic [BW_W-1:0]  BW_MAX  = BW_W'(B_MAX_WAIT);

  // Which port (if any) owns the read currently in flight in the sdram.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_A    = 2'd1,
    TAG_B    = 2'd2
  } tag_e;

  // Outcome of the slot decision taken on a sync cycle.
  typedef enum logic [1:0] {
    DEC_IDLE    = 2'd0,
    DEC_REFRESH = 2'd1,
    DEC_GRANT_A = 2'd2,
    DEC_GRANT_B = 2'd3
  } dec_e;

  dec_e              dec;

  logic              ram_we_q,   ram_we_d;
  logic              ram_oe_q,   ram_oe_d;
  logic [1:0]        ram_ds_q,   ram_ds_d;
  logic [19:0]       ram_addr_q, ram_addr_d;
  logic [15:0]       ram_din_q,  ram_din_d;
  logic              a_ack_q,    a_ack_d;
  logic              b_ack_q,    b_ack_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [15:0]       a_dout_q,   a_dout_d;
  logic [15:0]       b_dout_q,   b_dout_d;
  tag_e              tag_q,      tag_d;
  logic [ACC_W-1:0]  acc_cnt_q,  acc_cnt_d;
  logic [BW_W-1:0]   b_wait_q,   b_wait_d;

  // Slot decision: refresh beats everything, a starved B beats A, A beats B.
  always_comb begin
    dec = DEC_IDLE;
    if (acc_cnt_q == ACC_MAX) begin
      dec = DEC_REFRESH;
    end else if (b_req && (!a_req || (b_wait_q >= BW_MAX))) begin
      dec = DEC_GRANT_B;
    end else if (a_req) begin
      dec = DEC_GRANT_A;
    end
  end

  // Next state: everything holds between sync pulses; acks and rvalids pulse.
  always_comb begin
    ram_we_d   = ram_we_q;
    ram_oe_d   = ram_oe_q;
    ram_ds_d   = ram_ds_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_dout_d   = a_dout_q;
    b_dout_d   = b_dout_q;
    tag_d      = tag_q;
    acc_cnt_d  = acc_cnt_q;
    b_wait_d   = b_wait_q;

    if (sync) begin
      // Data for the previous slot's read is on ram_dout at this boundary.
      if (tag_q == TAG_A) begin
        a_rvalid_d = 1'b1;
        a_dout_d   = ram_dout;
      end
      if (tag_q == TAG_B) begin
        b_rvalid_d = 1'b1;
        b_dout_d   = ram_dout;
      end

      unique case (dec)
        DEC_REFRESH: begin
          ram_we_d  = 1'b0;
          ram_oe_d  = 1'b0;
          tag_d     = TAG_NONE;
          acc_cnt_d = '0;
        end
        DEC_GRANT_B: begin
          ram_we_d   = b_we;
          ram_oe_d   = !b_we;
          ram_ds_d   = b_ds;
          ram_addr_d = b_addr;
          ram_din_d  = b_din;
          b_ack_d    = 1'b1;
          tag_d      = b_we ? TAG_NONE : TAG_B;
          acc_cnt_d  = acc_cnt_q + ACC_W'(1);
          b_wait_d   = '0;
        end
        DEC_GRANT_A: begin
          ram_we_d   = a_we;
          ram_oe_d   = !a_we;
          ram_ds_d   = a_ds;
          ram_addr_d = a_addr;
          ram_din_d  = a_din;
          a_ack_d    = 1'b1;
          tag_d      = a_we ? TAG_NONE : TAG_A;
          acc_cnt_d  = acc_cnt_q + ACC_W'(1);
          if (!b_req) begin
            b_wait_d = '0;
          end else if (b_wait_q != BW_MAX) begin
            b_wait_d = b_wait_q + BW_W'(1);
          end
        end
        default: begin
          ram_we_d  = 1'b0;
          ram_oe_d  = 1'b0;
          tag_d     = TAG_NONE;
          acc_cnt_d = '0;
          b_wait_d  = '0;
        end
      endcase
    end
  end

  // State register; reset discards any in-flight read along with everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we_q   <= 1'b0;
      ram_oe_q   <= 1'b0;
      ram_ds_q   <= 2'b00;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_dout_q   <= '0;
      b_dout_q   <= '0;
      tag_q      <= TAG_NONE;
      acc_cnt_q  <= '0;
      b_wait_q   <= '0;
    end else begin
      ram_we_q   <= ram_we_d;
      ram_oe_q   <= ram_oe_d;
      ram_ds_q   <= ram_ds_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
      tag_q      <= tag_d;
      acc_cnt_q  <= acc_cnt_d;
      b_wait_q   <= b_wait_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_oe   = ram_oe_q;
  assign ram_ds   = ram_ds_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_dout   = a_dout_q;
  assign b_dout   = b_dout_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Testbench for sdram_slot_arbiter: directed scenarios plus randomized traffic
// checked against a slot-history reference model.
module tb_sdram_slot_arbiter;

  localparam int REFRESH_EVERY = 8;
  localparam int B_MAX_WAIT    = 4;

  // Slot history codes used by the reference model.
  localparam int H_REF  = 0;
  localparam int H_B    = 1;
  localparam int H_A    = 2;
  localparam int H_IDLE = 3;

  logic        clk = 1'b0;
  logic        reset, sync;
  logic        a_req, a_we, a_ack, a_rvalid;
  logic [1:0]  a_ds;
  logic [19:0] a_addr;
  logic [15:0] a_din, a_dout;
  logic        b_req, b_we, b_ack, b_rvalid;
  logic [1:0]  b_ds;
  logic [19:0] b_addr;
  logic [15:0] b_din, b_dout;
  logic        ram_we, ram_oe;
  logic [1:0]  ram_ds;
  logic [19:0] ram_addr;
  logic [15:0] ram_din, ram_dout;

  int n_checks, n_errors;
  int phase;
  bit a_auto, b_auto;
  int a_pct, b_pct, we_pct, drop_pct;

  // Reference model state
  int          hist_out[$];
  bit          hist_breq[$];
  logic        e_a_ack, e_b_ack, e_a_rv, e_b_rv, e_we, e_oe;
  logic [1:0]  e_ds;
  logic [19:0] e_addr;
  logic [15:0] e_din, e_a_dout, e_b_dout;
  bit          pend_vld, pend_b;
  logic [15:0] pend_data;

  sdram_slot_arbiter #(.REFRESH_EVERY(REFRESH_EVERY), .B_MAX_WAIT(B_MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .sync(sync),
    .a_req(a_req), .a_we(a_we), .a_ds(a_ds), .a_addr(a_addr), .a_din(a_din),
    .a_ack(a_ack), .a_dout(a_dout), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_ds(b_ds), .b_addr(b_addr), .b_din(b_din),
    .b_ack(b_ack), .b_dout(b_dout), .b_rvalid(b_rvalid),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_ds(ram_ds), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // sdram stand-in: every address reads back a fixed pattern of itself.
  function automatic logic [15:0] sdram_word(logic [19:0] addr);
    return addr[15:0] ^ 16'h5A4A;
  endfunction

  assign ram_dout = ram_oe ? sdram_word(ram_addr) : 16'h0000;

  function automatic logic [75:0] act_vec();
    return {a_ack, b_ack, a_rvalid, b_rvalid, ram_we, ram_oe, ram_ds, ram_addr,
            ram_din, a_dout, b_dout};
  endfunction

  function automatic logic [75:0] exp_vec();
    return {e_a_ack, e_b_ack, e_a_rv, e_b_rv, e_we, e_oe, e_ds, e_addr,
            e_din, e_a_dout, e_b_dout};
  endfunction

  // Decide a slot from the history of slots since reset: refresh after a run
  // of REFRESH_EVERY grants; B promoted after B_MAX_WAIT A-grants it sat through
  // (refresh slots neither count nor break that streak).
  function automatic int model_decide(bit ar, bit br);
    int run;
    int waited;
    run = 0;
    waited = 0;
    for (int i = hist_out.size() - 1; i >= 0; i--) begin
      if (hist_out[i] == H_A || hist_out[i] == H_B) run++;
      else break;
    end
    if (run >= REFRESH_EVERY) return H_REF;
    for (int i = hist_out.size() - 1; i >= 0; i--) begin
      if (hist_out[i] == H_REF) continue;
      if (hist_out[i] == H_A && hist_breq[i]) waited++;
      else break;
    end
    if (br && (!ar || waited >= B_MAX_WAIT)) return H_B;
    if (ar) return H_A;
    return H_IDLE;
  endfunction

  task automatic new_a();
    a_req  = 1'b1;
    a_we   = ($urandom_range(99) < we_pct);
    a_ds   = 2'($urandom);
    a_addr = 20'($urandom);
    a_din  = 16'($urandom);
  endtask

  task automatic new_b();
    b_req  = 1'b1;
    b_we   = ($urandom_range(99) < we_pct);
    b_ds   = 2'($urandom);
    b_addr = 20'($urandom);
    b_din  = 16'($urandom);
  endtask

  // One clock: advance the model from the inputs the DUT sampled, then
  // generate sync and the requester behaviour for the next cycle.
  task automatic step();
    logic        s_reset, s_sync, s_ar, s_br, s_aw, s_bw;
    logic [1:0]  s_ads, s_bds;
    logic [19:0] s_aa, s_ba;
    logic [15:0] s_ad, s_bd;
    int          d;
    s_reset = reset; s_sync = sync;
    s_ar = a_req; s_aw = a_we; s_ads = a_ds; s_aa = a_addr; s_ad = a_din;
    s_br = b_req; s_bw = b_we; s_bds = b_ds; s_ba = b_addr; s_bd = b_din;
    @(posedge clk);
    #1;
    e_a_ack = 1'b0; e_b_ack = 1'b0; e_a_rv = 1'b0; e_b_rv = 1'b0;
    if (s_reset) begin
      e_we = 1'b0; e_oe = 1'b0; e_ds = '0; e_addr = '0; e_din = '0;
      e_a_dout = '0; e_b_dout = '0;
      pend_vld = 1'b0;
      hist_out.delete();
      hist_breq.delete();
    end else if (s_sync) begin
      if (pend_vld && pend_b) begin
        e_b_rv = 1'b1; e_b_dout = pend_data;
      end else if (pend_vld) begin
        e_a_rv = 1'b1; e_a_dout = pend_data;
      end
      pend_vld = 1'b0;
      d = model_decide(s_ar, s_br);
      hist_out.push_back(d);
      hist_breq.push_back(s_br);
      if (d == H_A) begin
        e_a_ack = 1'b1; e_we = s_aw; e_oe = !s_aw;
        e_ds = s_ads; e_addr = s_aa; e_din = s_ad;
        if (!s_aw) begin pend_vld = 1'b1; pend_b = 1'b0; pend_data = sdram_word(s_aa); end
      end else if (d == H_B) begin
        e_b_ack = 1'b1; e_we = s_bw; e_oe = !s_bw;
        e_ds = s_bds; e_addr = s_ba; e_din = s_bd;
        if (!s_bw) begin pend_vld = 1'b1; pend_b = 1'b1; pend_data = sdram_word(s_ba); end
      end else begin
        e_we = 1'b0; e_oe = 1'b0;
      end
    end
    phase = (phase + 1) % 8;
    sync  = (phase == 0);
    if (a_ack) a_req = 1'b0;
    else if (a_req && a_auto && $urandom_range(999) < drop_pct) a_req = 1'b0;
    if (a_auto && !a_req && $urandom_range(99) < a_pct) new_a();
    if (b_ack) b_req = 1'b0;
    else if (b_req && b_auto && $urandom_range(999) < drop_pct) b_req = 1'b0;
    if (b_auto && !b_req && $urandom_range(99) < b_pct) new_b();
  endtask

  // Advance until the next cycle presented to the DUT carries sync.
  task automatic to_sync();
    for (int i = 0; i < 8 && !sync; i++) step();
  endtask

  task automatic short_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (act_vec() !== 76'd0) begin
        n_errors++;
        $display("FAIL reset_hold cycle %0d: outputs=%h expected=%h", i, act_vec(), 76'd0);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      n_checks++;
      if (act_vec() !== 76'd0) begin
        n_errors++;
        $display("FAIL reset_idle cycle %0d: outputs=%h expected=%h", i, act_vec(), 76'd0);
      end
    end
  endtask

  task automatic test_a_write();
    to_sync();
    a_req = 1'b1; a_we = 1'b1; a_ds = 2'b11; a_addr = 20'h12345; a_din = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ({a_ack, b_ack, ram_we, ram_oe, ram_ds, ram_addr, ram_din} !==
          {(i == 0), 1'b0, 1'b1, 1'b0, 2'b11, 20'h12345, 16'hBEEF}) begin
        n_errors++;
        $display("FAIL a_write cycle %0d: ack=%b we=%b oe=%b ds=%b addr=%h din=%h expected ack=%b we=1 oe=0 ds=11 addr=12345 din=beef",
                 i, a_ack, ram_we, ram_oe, ram_ds, ram_addr, ram_din, (i == 0));
      end
    end
    step();
    n_checks++;
    if ({a_ack, ram_we, ram_oe, ram_addr} !== {1'b0, 1'b0, 1'b0, 20'h12345}) begin
      n_errors++;
      $display("FAIL a_write_end: ack=%b we=%b oe=%b addr=%h expected ack=0 we=0 oe=0 addr=12345",
               a_ack, ram_we, ram_oe, ram_addr);
    end
  endtask

  task automatic test_a_read();
    to_sync();
    a_req = 1'b1; a_we = 1'b0; a_ds = 2'b11; a_addr = 20'h00010; a_din = 16'h0000;
    step();
    n_checks++;
    if ({a_ack, ram_oe, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 20'h00010}) begin
      n_errors++;
      $display("FAIL a_read_cmd: ack=%b oe=%b we=%b addr=%h expected ack=1 oe=1 we=0 addr=00010",
               a_ack, ram_oe, ram_we, ram_addr);
    end
    for (int i = 1; i < 8; i++) begin
      step();
      n_checks++;
      if ({a_rvalid, b_rvalid, a_ack, ram_oe} !== 4'b0001) begin
        n_errors++;
        $display("FAIL a_read_wait cycle %0d: a_rvalid=%b b_rvalid=%b ack=%b oe=%b expected 0 0 0 1",
                 i, a_rvalid, b_rvalid, a_ack, ram_oe);
      end
    end
    step();
    n_checks++;
    if ({a_rvalid, b_rvalid, a_dout} !== {1'b1, 1'b0, 16'h5A5A}) begin
      n_errors++;
      $display("FAIL a_read_data: a_rvalid=%b b_rvalid=%b a_dout=%h expected 1 0 5a5a",
               a_rvalid, b_rvalid, a_dout);
    end
    step();
    n_checks++;
    if ({a_rvalid, b_rvalid, a_dout} !== {1'b0, 1'b0, 16'h5A5A}) begin
      n_errors++;
      $display("FAIL a_read_after: a_rvalid=%b b_rvalid=%b a_dout=%h expected 0 0 5a5a",
               a_rvalid, b_rvalid, a_dout);
    end
  endtask

  task automatic test_saturated();
    int exp_seq[11] = '{H_A, H_A, H_A, H_A, H_B, H_A, H_A, H_A, H_REF, H_A, H_B};
    int got;
    short_reset();
    we_pct = 0; a_pct = 100; b_pct = 100; drop_pct = 0;
    a_auto = 1'b1; b_auto = 1'b1;
    new_a();
    new_b();
    to_sync();
    for (int s = 0; s < 11; s++) begin
      for (int k = 0; k < 8; k++) begin
        step();
        if (k == 0) begin
          got = a_ack ? H_A : (b_ack ? H_B : H_REF);
          n_checks++;
          if (got !== exp_seq[s] || (a_ack && b_ack)) begin
            n_errors++;
            $display("FAIL sat_slot %0d: outcome=%0d (a_ack=%b b_ack=%b) expected=%0d",
                     s, got, a_ack, b_ack, exp_seq[s]);
          end
        end
        n_checks++;
        if (act_vec() !== exp_vec()) begin
          n_errors++;
          $display("FAIL sat_model slot %0d cycle %0d: outputs=%h expected=%h", s, k, act_vec(), exp_vec());
        end
      end
    end
    for (int i = 0; i < 160; i++) begin
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_errors++;
        $display("FAIL sat_run cycle %0d: outputs=%h expected=%h", i, act_vec(), exp_vec());
      end
    end
    a_auto = 1'b0; b_auto = 1'b0;
  endtask

  task automatic test_refresh_a_only();
    logic exp_g;
    b_req = 1'b0;
    short_reset();
    we_pct = 50; a_pct = 100; drop_pct = 0;
    a_auto = 1'b1; b_auto = 1'b0;
    new_a();
    to_sync();
    for (int s = 0; s < 27; s++) begin
      exp_g = ((s % 9) != 8);
      for (int k = 0; k < 8; k++) begin
        step();
        if (k == 0) begin
          n_checks++;
          if ({a_ack, b_ack, (ram_we | ram_oe)} !== {exp_g, 1'b0, exp_g}) begin
            n_errors++;
            $display("FAIL refresh_slot %0d: a_ack=%b b_ack=%b access=%b expected %b 0 %b",
                     s, a_ack, b_ack, (ram_we | ram_oe), exp_g, exp_g);
          end
        end
        n_checks++;
        if (act_vec() !== exp_vec()) begin
          n_errors++;
          $display("FAIL refresh_model slot %0d cycle %0d: outputs=%h expected=%h", s, k, act_vec(), exp_vec());
        end
      end
    end
    a_auto = 1'b0;
    a_req = 1'b0;
  endtask

  task automatic test_reset_during_read();
    short_reset();
    to_sync();
    a_req = 1'b1; a_we = 1'b0; a_ds = 2'b01; a_addr = 20'h00ABC; a_din = 16'h0000;
    step();
    n_checks++;
    if ({a_ack, ram_oe} !== 2'b11) begin
      n_errors++;
      $display("FAIL rst_read_ack: ack=%b oe=%b expected 1 1", a_ack, ram_oe);
    end
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (act_vec() !== 76'd0) begin
      n_errors++;
      $display("FAIL rst_read_state: outputs=%h expected=%h", act_vec(), 76'd0);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (act_vec() !== 76'd0) begin
        n_errors++;
        $display("FAIL rst_read_discard cycle %0d: outputs=%h expected=%h", i, act_vec(), 76'd0);
      end
    end
    to_sync();
    a_req = 1'b1; a_we = 1'b0; a_ds = 2'b11; a_addr = 20'h00055; a_din = 16'h0000;
    step();
    n_checks++;
    if ({a_ack, ram_oe, ram_addr} !== {1'b1, 1'b1, 20'h00055}) begin
      n_errors++;
      $display("FAIL rst_reread_ack: ack=%b oe=%b addr=%h expected 1 1 00055", a_ack, ram_oe, ram_addr);
    end
    for (int i = 1; i < 8; i++) step();
    step();
    n_checks++;
    if ({a_rvalid, b_rvalid, a_dout} !== {1'b1, 1'b0, 16'h5A1F}) begin
      n_errors++;
      $display("FAIL rst_reread_data: a_rvalid=%b b_rvalid=%b a_dout=%h expected 1 0 5a1f",
               a_rvalid, b_rvalid, a_dout);
    end
  endtask

  task automatic test_random();
    short_reset();
    we_pct = 50; drop_pct = 5;
    a_auto = 1'b1; b_auto = 1'b1;
    for (int r = 0; r < 4; r++) begin
      a_pct = int'($urandom_range(100, 20));
      b_pct = int'($urandom_range(100, 20));
      for (int i = 0; i < 500; i++) begin
        step();
        n_checks++;
        if (act_vec() !== exp_vec()) begin
          n_errors++;
          $display("FAIL random round %0d cycle %0d: outputs=%h expected=%h", r, i, act_vec(), exp_vec());
        end
      end
    end
    a_auto = 1'b0; b_auto = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; sync = 1'b0; phase = 7;
    a_req = 1'b0; a_we = 1'b0; a_ds = '0; a_addr = '0; a_din = '0;
    b_req = 1'b0; b_we = 1'b0; b_ds = '0; b_addr = '0; b_din = '0;
    a_auto = 1'b0; b_auto = 1'b0;
    a_pct = 0; b_pct = 0; we_pct = 0; drop_pct = 0;
    e_a_ack = 1'b0; e_b_ack = 1'b0; e_a_rv = 1'b0; e_b_rv = 1'b0;
    e_we = 1'b0; e_oe = 1'b0; e_ds = '0; e_addr = '0; e_din = '0;
    e_a_dout = '0; e_b_dout = '0;
    pend_vld = 1'b0; pend_b = 1'b0; pend_data = '0;

    test_reset();
    test_a_write();
    test_a_read();
    test_saturated();
    test_refresh_a_only();
    test_reset_during_read();
    test_random();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
